pc_pipelined: RTL and testbench
===============================

// Module: pc_pipelined
// PURPOSE
//  Program counter for the pipelined MIPS-subset CPU. Holds the fetch address and advances it by 4
//  every cycle. It stalls on a memory hazard and redirects on the branch/jump resolved in EXEC1
//  (one architectural delay slot). It flags halt when the PC reaches 0x00000000. A small stage
//  FSM supplies the fetch/exec1/exec2 stage-valid strobes.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  address loaded by reset
//  HALT_ADDR     32'h00000000  reaching this address raises pc_halt
// PORTS
//  clk               in   1   single clock; all state updates on posedge
//  reset             in   1   asynchronous, active-high
//  fetch             in   1   FETCH stage valid (from stage FSM)
//  exec1             in   1   EXEC1 stage valid; branch/jump resolution qualified by it
//  exec2             in   1   EXEC2 stage valid; accepted, no effect on next address
//  instruction_code  in   7   decoded opcode of the instruction in EXEC1 (package enum)
//  offset            in  16   branch immediate of the EXEC1 instruction
//  instr_index       in  26   J/JAL target field of the EXEC1 instruction
//  register_data     in  32   rs value for JR/JALR
//  zero              in   1   branch compare flag: rs==rt (BEQ/BNE) or rs==0 (REGIMM/BxxZ)
//  positive          in   1   rs > 0 (signed)
//  negative          in   1   rs < 0 (signed)
//  memory_hazard     in   1   stall request: hold PC this cycle
//  address           out 32   current fetch address
//  pc_halt           out  1   high when address==HALT_ADDR (not during reset)
// BEHAVIOUR
//  - Reset (async): address=RESET_VECTOR, pc_halt=0, any pending redirect is cleared.
//    Reset asserted mid-run overrides everything immediately.
//  - Each posedge, next-address priority:
//    reset > halted hold > memory_hazard==1 hold > taken branch/jump in EXEC1 > address+4.
//  - Only memory_hazard==1 stalls. X/0 is treated as no stall.
//  - Any instruction_code outside the branch/jump set, including X/unknown, means sequential.
//  - Redirect occurs when exec1==1 and the code is a taken control transfer. The current address
//    is the delay-slot address (branch PC+4), so:
//    * branch target = address + (sign_ext(offset) << 2), 32-bit wrap-around
//    * J/JAL target  = {address[31:28], instr_index, 2'b00}
//    * JR/JALR target = register_data (no alignment fixup)
//  - Branch conditions:
//    * BEQ: zero
//    * BNE: !zero
//    * BGTZ: positive
//    * BLEZ: zero|negative
//    * BLTZ, BLTZAL: negative
//    * BGEZ, BGEZAL: zero|positive
//    * J/JAL/JR/JALR: always taken
//  - Hazard coincident with a taken branch: stall wins. The pipeline freezes, so EXEC1 still holds
//    the branch next cycle, and the redirect takes effect once the hazard drops (no lost redirect).
//  - Latency: a redirect is visible on address one cycle after the EXEC1 evaluation. Exactly one
//    delay-slot instruction is fetched.
//  - pc_halt is combinational, (address==HALT_ADDR)&&!reset. While it is high the PC holds its value.
//  - Stage FSM (sub-module): reset -> FILL0 (fetch=1), then FILL1 (fetch,exec1=1), then RUN (all 1).
//    In any state, pc_halt -> HALTED (all 0), which is held until reset. Strobes register on posedge.
// STRUCTURE
//  - Shared package cpu_pkg: instruction_code enum (7-bit; J, JAL, JR, JALR, BEQ, BNE, BGTZ, BLEZ,
//    BLTZ, BGEZ, BLTZAL, BGEZAL, plus non-control codes), RESET_VECTOR, HALT_ADDR constants.
//  - Sub-module pc_stage_fsm (states FILL0/FILL1/RUN/HALTED) generates fetch/exec1/exec2 from
//    clk, reset and pc_halt. The top contains the address register, target adders and the
//    condition mux.
// TESTING
//  1. Reset pulse, other inputs idle/X -> address=BFC00000 at release, then BFC00004, 08, 0C, 10, 14
//     on successive cycles.
//  2. At address BFC00014, memory_hazard=1 for one edge -> address stays BFC00014, then BFC00018,
//     BFC0001C.
//  3. BEQ in EXEC1 at address BFC00008, zero=1, offset=16'h0003 -> next address BFC00014.
//     Same with zero=0 -> BFC0000C.
//  4. BNE, offset=16'hFFFE, zero=0, at BFC00010 -> BFC00008 (negative offset).
//  5. J with instr_index=26'h0000010 at BFC00008 -> B0000040. JR with register_data=0 -> address 0,
//     pc_halt=1, PC frozen, FSM strobes drop to 0.
//  6. Hazard and taken BEQ on the same edge -> address held one cycle, then the branch target.
//     Reset asserted mid-run -> immediate BFC00000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode types and constants for the pipelined MIPS-subset CPU.
// Helpers here are pure combinational functions used by fetch-side logic.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [6:0] {
    OP_NOP    = 7'h00,
    OP_ADD    = 7'h01,
    OP_SUB    = 7'h02,
    OP_AND    = 7'h03,
    OP_OR     = 7'h04,
    OP_SLT    = 7'h05,
    OP_LW     = 7'h08,
    OP_SW     = 7'h09,
    OP_LUI    = 7'h0A,
    OP_J      = 7'h10,
    OP_JAL    = 7'h11,
    OP_JR     = 7'h12,
    OP_JALR   = 7'h13,
    OP_BEQ    = 7'h18,
    OP_BNE    = 7'h19,
    OP_BGTZ   = 7'h1A,
    OP_BLEZ   = 7'h1B,
    OP_BLTZ   = 7'h1C,
    OP_BGEZ   = 7'h1D,
    OP_BLTZAL = 7'h1E,
    OP_BGEZAL = 7'h1F
  } instr_code_t;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_BRANCH,
    TGT_JUMP,
    TGT_REG
  } target_kind_t;

  typedef enum logic [1:0] {
    ST_FILL0,
    ST_FILL1,
    ST_RUN,
    ST_HALTED
  } stage_state_t;

  // Unknown or non-control codes fall through to the default arm: no redirect.
  function automatic logic branch_taken(input instr_code_t code,
                                        input logic zero,
                                        input logic positive,
                                        input logic negative);
    logic t;
    t = 1'b0;
    case (code)
      OP_J, OP_JAL, OP_JR, OP_JALR: t = 1'b1;
      OP_BEQ:                       t = zero;
      OP_BNE:                       t = !zero;
      OP_BGTZ:                      t = positive;
      OP_BLEZ:                      t = zero | negative;
      OP_BLTZ, OP_BLTZAL:           t = negative;
      OP_BGEZ, OP_BGEZAL:           t = zero | positive;
      default:                      t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic target_kind_t target_kind(input instr_code_t code);
    target_kind_t k;
    k = TGT_NONE;
    case (code)
      OP_J, OP_JAL:                       k = TGT_JUMP;
      OP_JR, OP_JALR:                     k = TGT_REG;
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ,
      OP_BLTZ, OP_BGEZ, OP_BLTZAL,
      OP_BGEZAL:                          k = TGT_BRANCH;
      default:                            k = TGT_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [31:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/pc_stage_fsm.sv
// Stage-valid strobe generator: FILL0 -> FILL1 -> RUN, any state -> HALTED on pc_halt.
// Strobes are registered; HALTED is sticky until reset.
module pc_stage_fsm
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pc_halt,
  output logic fetch,
  output logic exec1,
  output logic exec2
);

  stage_state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FILL0;
      fetch <= 1'b1;
      exec1 <= 1'b0;
      exec2 <= 1'b0;
    end else if (pc_halt || state == ST_HALTED) begin
      state <= ST_HALTED;
      fetch <= 1'b0;
      exec1 <= 1'b0;
      exec2 <= 1'b0;
    end else begin
      case (state)
        ST_FILL0: begin
          state <= ST_FILL1;
          fetch <= 1'b1;
          exec1 <= 1'b1;
          exec2 <= 1'b0;
        end
        ST_FILL1, ST_RUN: begin
          state <= ST_RUN;
          fetch <= 1'b1;
          exec1 <= 1'b1;
          exec2 <= 1'b1;
        end
        default: begin
          state <= ST_HALTED;
          fetch <= 1'b0;
          exec1 <= 1'b0;
          exec2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_pipelined.sv
// Fetch program counter: +4 per cycle, stall on memory_hazard, redirect from EXEC1 (one delay slot).
// Redirect lands on address one cycle after EXEC1 evaluates; pc_halt freezes the PC at HALT_ADDR.
module pc_pipelined
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = cpu_pkg::HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch,
  input  logic        exec1,
  input  logic        exec2,
  input  instr_code_t instruction_code,
  input  logic [15:0] offset,
  input  logic [25:0] instr_index,
  input  logic [31:0] register_data,
  input  logic        zero,
  input  logic        positive,
  input  logic        negative,
  input  logic        memory_hazard,
  output logic [31:0] address,
  output logic        pc_halt
);

  logic [31:0]  seq_address;
  logic [31:0]  branch_target;
  logic [31:0]  jump_target;
  logic [31:0]  next_address;
  logic         taken;
  target_kind_t kind;
  logic         stage_fetch;
  logic         stage_exec1;
  logic         stage_exec2;
  logic         unused_strobes;

  // Address already points at the delay slot, so targets are relative to it.
  assign seq_address   = address + 32'd4;
  assign branch_target = address + branch_disp(offset);
  assign jump_target   = {address[31:28], instr_index, 2'b00};

  assign pc_halt = (address == HALT_ADDR) && !reset;

  assign taken = branch_taken(instruction_code, zero, positive, negative);
  assign kind  = target_kind(instruction_code);

  // A stalled branch stays in EXEC1, so it is simply re-evaluated after the hazard clears.
  always_comb begin
    next_address = seq_address;
    if (pc_halt) begin
      next_address = address;
    end else if (memory_hazard) begin
      next_address = address;
    end else if (exec1 && taken) begin
      case (kind)
        TGT_BRANCH: next_address = branch_target;
        TGT_JUMP:   next_address = jump_target;
        TGT_REG:    next_address = register_data;
        default:    next_address = seq_address;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address <= RESET_VECTOR;
    end else begin
      address <= next_address;
    end
  end

  pc_stage_fsm u_stage_fsm (
    .clk     (clk),
    .reset   (reset),
    .pc_halt (pc_halt),
    .fetch   (stage_fetch),
    .exec1   (stage_exec1),
    .exec2   (stage_exec2)
  );

  // Strobe inputs other than exec1 carry no next-address information.
  assign unused_strobes = ^{fetch, exec2, stage_fetch, stage_exec1, stage_exec2};

endmodule

// File: tb/tb_pc_pipelined.sv
// Directed and randomized bench for pc_pipelined against a rs/rt-level reference model.
`timescale 1ns/1ps
module tb_pc_pipelined;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch, exec1, exec2;
  instr_code_t instruction_code;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] register_data;
  logic        zero, positive, negative, memory_hazard;
  logic [31:0] address;
  logic        pc_halt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;
  int          since_reset;
  bit          halted;

  always #5 clk = ~clk;

  pc_pipelined dut (
    .clk              (clk),
    .reset            (reset),
    .fetch            (fetch),
    .exec1            (exec1),
    .exec2            (exec2),
    .instruction_code (instruction_code),
    .offset           (offset),
    .instr_index      (instr_index),
    .register_data    (register_data),
    .zero             (zero),
    .positive         (positive),
    .negative         (negative),
    .memory_hazard    (memory_hazard),
    .address          (address),
    .pc_halt          (pc_halt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_strobes();
    if (halted)           return 32'b000;
    if (since_reset == 0) return 32'b100;
    if (since_reset == 1) return 32'b110;
    return 32'b111;
  endfunction

  function automatic logic [31:0] obs_strobes();
    return {29'b0, dut.stage_fetch, dut.stage_exec1, dut.stage_exec2};
  endfunction

  task automatic drive(input instr_code_t c, input logic e1, input logic hz,
                       input logic [15:0] off, input logic [25:0] idx, input logic [31:0] rd,
                       input logic z, input logic p, input logic n);
    instruction_code = c; exec1 = e1; memory_hazard = hz;
    offset = off; instr_index = idx; register_data = rd;
    zero = z; positive = p; negative = n;
    fetch = 1'b1; exec2 = 1'b1;
  endtask

  // One clock edge; nxt is the address required after it.
  task automatic tick(input logic [31:0] nxt, input string tag);
    if (exp_addr == HALT_ADDR) halted = 1'b1;
    @(posedge clk); #1;
    since_reset++;
    exp_addr = nxt;
    chk({tag, "/addr"}, address, exp_addr);
    chk({tag, "/halt"}, {31'b0, pc_halt}, {31'b0, exp_addr == HALT_ADDR});
    chk({tag, "/stages"}, obs_strobes(), exp_strobes());
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; #1;
    chk({tag, "/async_addr"}, address, RESET_VECTOR);
    chk({tag, "/async_halt"}, {31'b0, pc_halt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_addr = RESET_VECTOR; since_reset = 0; halted = 1'b0;
    chk({tag, "/stages"}, obs_strobes(), exp_strobes());
  endtask

  function automatic bit ref_taken(input instr_code_t c, input int rs, input int rt);
    case (c)
      OP_J, OP_JAL, OP_JR, OP_JALR: return 1'b1;
      OP_BEQ:                       return rs == rt;
      OP_BNE:                       return rs != rt;
      OP_BGTZ:                      return rs > 0;
      OP_BLEZ:                      return rs <= 0;
      OP_BLTZ, OP_BLTZAL:           return rs < 0;
      OP_BGEZ, OP_BGEZAL:           return rs >= 0;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input instr_code_t c, input logic [31:0] pc,
                                             input logic [15:0] off, input logic [25:0] idx,
                                             input logic [31:0] rd);
    case (c)
      OP_J, OP_JAL:   return (pc & 32'hF000_0000) | (32'(idx) * 32'd4);
      OP_JR, OP_JALR: return rd;
      default:        return pc + 32'($signed(off)) * 32'd4;
    endcase
  endfunction

  instr_code_t codes[20] = '{OP_NOP, OP_ADD, OP_SUB, OP_LW, OP_SW, OP_LUI, OP_J, OP_JAL,
                             OP_JR, OP_JALR, OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_BLTZ,
                             OP_BGEZ, OP_BLTZAL, OP_BGEZAL, OP_BEQ, OP_BNE};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch with idle/unknown control inputs.
    drive(instr_code_t'(7'bx), 1'b1, 1'bx, 16'hxxxx, 26'hx, 32'hx, 1'bx, 1'bx, 1'bx);
    do_reset("por");
    for (int i = 1; i <= 5; i++) tick(RESET_VECTOR + 32'(4 * i), "seq");

    drive(OP_NOP, 1'b1, 1'b1, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(32'hBFC0_0014, "hz_hold");
    memory_hazard = 1'b0;
    tick(32'hBFC0_0018, "hz_rel0");
    tick(32'hBFC0_001C, "hz_rel1");

    // Conditional branches, both directions.
    do_reset("rst_mid1");
    tick(32'hBFC0_0004, "pre1");
    tick(32'hBFC0_0008, "pre2");
    drive(OP_BEQ, 1'b1, 1'b0, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(32'hBFC0_0014, "beq_taken");

    drive(OP_NOP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset("rst_mid2");
    tick(32'hBFC0_0004, "pre3");
    tick(32'hBFC0_0008, "pre4");
    drive(OP_BEQ, 1'b1, 1'b0, 16'h0003, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(32'hBFC0_000C, "beq_not");
    drive(OP_NOP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(32'hBFC0_0010, "pre5");
    drive(OP_BNE, 1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(32'hBFC0_0008, "bne_back");

    // Jumps, ending at the halt address.
    drive(OP_J, 1'b1, 1'b0, 16'h0, 26'h000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(32'hB000_0040, "j");
    drive(OP_JR, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_0000, "jr_halt");
    drive(OP_NOP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_0000, "halt_hold0");
    drive(OP_J, 1'b1, 1'b0, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_0000, "halt_hold1");

    // Hazard coincident with a taken branch.
    drive(OP_NOP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset("rst_halted");
    tick(32'hBFC0_0004, "pre6");
    tick(32'hBFC0_0008, "pre7");
    drive(OP_BEQ, 1'b1, 1'b1, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(32'hBFC0_0008, "hz_br_hold");
    memory_hazard = 1'b0;
    tick(32'hBFC0_0014, "hz_br_redir");

    // Randomized run against the reference model.
    drive(OP_NOP, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_reset("rst_rand");
    for (int k = 0; k < 400; k++) begin
      int          rs, rt;
      instr_code_t c;
      logic        e1, hz;
      logic [15:0] off;
      logic [25:0] idx;
      logic [31:0] rd, nxt;
      bit          z;
      rs  = int'($urandom_range(0, 6)) - 3;
      rt  = ($urandom_range(0, 1) == 1) ? rs : int'($urandom_range(0, 6)) - 3;
      c   = ($urandom_range(0, 7) == 0) ? instr_code_t'(7'($urandom_range(0, 127)))
                                        : codes[$urandom_range(0, 19)];
      e1  = ($urandom_range(0, 7) != 0);
      hz  = ($urandom_range(0, 4) == 0);
      off = 16'($urandom);
      idx = 26'($urandom);
      rd  = ($urandom_range(0, 49) == 0) ? 32'h0 : 32'($urandom);
      z   = (c == OP_BEQ || c == OP_BNE) ? (rs == rt) : (rs == 0);
      drive(c, e1, hz, off, idx, rd, z, rs > 0, rs < 0);
      if (exp_addr == HALT_ADDR || hz)  nxt = exp_addr;
      else if (e1 && ref_taken(c, rs, rt)) nxt = ref_target(c, exp_addr, off, idx, rd);
      else                              nxt = exp_addr + 32'd4;
      tick(nxt, "rand");
      if (exp_addr == HALT_ADDR && $urandom_range(0, 2) == 0) do_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
